// File: rtl/hack_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hack_mem_pkg: shared RAM sizing, port-ID encoding and burst-counter width (rev 1.0)
// ----------------------------------------------------------------------------
package hack_mem_pkg;

  localparam int DEFAULT_DEPTH = 16384;
  localparam int DEFAULT_WIDTH = 16;
  localparam int BURST_W       = 4;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_arbiter_ram: single-port RAM, registered read returning pre-write data (rev 1.0)
// ----------------------------------------------------------------------------
module ram_arbiter_ram
  import hack_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_arbiter: two-port arbiter with burst hold in front of a single-port RAM;
// define RAM_ARBITER_RR_EN for round-robin tie-breaking instead of port-0 priority (rev 1.0)
// ----------------------------------------------------------------------------
module ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic                     i_CLK,
  input  logic                     i_RESET_n,
  input  logic                     i_Req_0,
  input  logic                     i_We_0,
  input  logic [$clog2(DEPTH)-1:0] i_Addr_0,
  input  logic [WIDTH-1:0]         i_Data_0,
  input  logic                     i_Lock_0,
  input  logic                     i_Req_1,
  input  logic                     i_We_1,
  input  logic [$clog2(DEPTH)-1:0] i_Addr_1,
  input  logic [WIDTH-1:0]         i_Data_1,
  input  logic                     i_Lock_1,
  output logic                     o_Gnt_0,
  output logic                     o_Rvalid_0,
  output logic [WIDTH-1:0]         o_Rdata_0,
  output logic                     o_Gnt_1,
  output logic                     o_Rvalid_1,
  output logic [WIDTH-1:0]         o_Rdata_1
);

  localparam int                 AW        = $clog2(DEPTH);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_SAT = '1;
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  logic [1:0]         req;
  logic [1:0]         lock;
  logic [1:0]         we_in;
  port_id_t           holder;
  port_id_t           gnt_port;
  port_id_t           tie_winner;
  logic               holder_valid;
  logic               gnt_valid;
  logic               hold;
  logic               capped;
  logic [BURST_W-1:0] burst_cnt;
  logic               rvalid_0;
  logic               rvalid_1;
  logic [AW-1:0]      ram_addr;
  logic [WIDTH-1:0]   ram_wdata;
  logic [WIDTH-1:0]   ram_rdata;
  logic               ram_we;

  assign req   = {i_Req_1, i_Req_0};
  assign lock  = {i_Lock_1, i_Lock_0};
  assign we_in = {i_We_1, i_We_0};

`ifdef RAM_ARBITER_RR_EN
  port_id_t last_port;

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      last_port <= PORT1;
    end else if (gnt_valid) begin
      last_port <= gnt_port;
    end
  end

  assign tie_winner = other_port(last_port);
`else
  assign tie_winner = PORT0;
`endif

  // The port granted last cycle keeps the bus while it stays locked, unless it
  // has used up its burst allowance and the other port is waiting.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = PORT0;
    hold      = holder_valid && req[holder] && lock[holder];
    capped    = (burst_cnt >= BURST_CAP) && req[other_port(holder)];
    if (!i_RESET_n) begin
      gnt_valid = 1'b0;
    end else if (hold) begin
      gnt_valid = 1'b1;
      gnt_port  = capped ? other_port(holder) : holder;
    end else if (req[PORT0] && req[PORT1]) begin
      gnt_valid = 1'b1;
      gnt_port  = tie_winner;
    end else if (req[PORT0]) begin
      gnt_valid = 1'b1;
      gnt_port  = PORT0;
    end else if (req[PORT1]) begin
      gnt_valid = 1'b1;
      gnt_port  = PORT1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      holder_valid <= 1'b0;
      holder       <= PORT0;
      burst_cnt    <= '0;
      rvalid_0     <= 1'b0;
      rvalid_1     <= 1'b0;
    end else begin
      holder_valid <= gnt_valid;
      holder       <= gnt_port;
      // A locked transfer by a new holder starts a fresh run at one.
      if (!gnt_valid || !lock[gnt_port]) begin
        burst_cnt <= '0;
      end else if (holder_valid && (gnt_port == holder)) begin
        if (burst_cnt != BURST_SAT) begin
          burst_cnt <= burst_cnt + BURST_ONE;
        end
      end else begin
        burst_cnt <= BURST_ONE;
      end
      rvalid_0 <= gnt_valid && (gnt_port == PORT0) && !we_in[PORT0];
      rvalid_1 <= gnt_valid && (gnt_port == PORT1) && !we_in[PORT1];
    end
  end

  assign ram_addr  = (gnt_port == PORT1) ? i_Addr_1 : i_Addr_0;
  assign ram_wdata = (gnt_port == PORT1) ? i_Data_1 : i_Data_0;
  assign ram_we    = gnt_valid && we_in[gnt_port];

  ram_arbiter_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (i_CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign o_Gnt_0    = gnt_valid && (gnt_port == PORT0);
  assign o_Gnt_1    = gnt_valid && (gnt_port == PORT1);
  assign o_Rvalid_0 = rvalid_0 && i_RESET_n;
  assign o_Rvalid_1 = rvalid_1 && i_RESET_n;
  assign o_Rdata_0  = ram_rdata;
  assign o_Rdata_1  = ram_rdata;

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 16384: RAM depth in words; address width is clog2(DEPTH).
REQ-002 SHALL have parameter WIDTH, default 16: data word width.
REQ-003 SHALL have parameter MAX_BURST, default 4, legal range 1..15: maximum consecutive locked grants to one port.
REQ-004 SHALL have port i_CLK  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port i_RESET_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have, for each p in {0,1}, port i_Req_p  input  1  request; the command is held stable until granted.
REQ-007 SHALL have i_We_p  input  1  write (1) or read (0) command qualifier.
REQ-008 SHALL have i_Addr_p  input  clog2(DEPTH)  word address.
REQ-009 SHALL have i_Data_p  input  WIDTH  write data.
REQ-010 SHALL have i_Lock_p  input  1  burst-hold request.
REQ-011 SHALL have o_Gnt_p  output  1  combinational grant; a transfer is accepted when i_Req_p and o_Gnt_p are both high.
REQ-012 SHALL have o_Rvalid_p  output  1  registered read-data-valid flag.
REQ-013 SHALL have o_Rdata_p  output  WIDTH  read data; meaningful only while o_Rvalid_p is high.

Function
REQ-014 SHALL assert at most one o_Gnt_p per cycle, and only to a requesting port; with no requests, both grants SHALL be low.
REQ-015 SHALL drive the internal RAM address, data and write enable from the granted port; the write enable SHALL be low when no grant is given.
REQ-016 SHALL, for a read accepted in cycle N, assert o_Rvalid_p for exactly cycle N+1, with o_Rdata_p equal to the RAM content at i_Addr_p before any write in cycle N.
REQ-017 SHALL NOT assert o_Rvalid_p for accepted writes.
REQ-018 SHALL sustain back-to-back transfers, one per cycle, with no bubble between grants.
REQ-019 SHALL grant port 0 when both ports request and no burst is active (fixed-priority mode).
REQ-020 SHALL implement burst hold as follows:
- Tracking: the port granted in cycle N keeps the grant in N+1 if it still requests and i_Lock is high; a burst counter counts consecutive accepted locked transfers.
- Cap: after MAX_BURST consecutive transfers, if the other port is requesting, the grant SHALL go to the other port for at least one cycle.
- Counter clear: the counter SHALL clear when the grant changes port or the holder drops i_Req or i_Lock.
REQ-021 SHALL treat simultaneous requests to the same address (one read, one write) as two ordinary serialized transfers; no forwarding is performed.
REQ-022 SHALL tie a port's o_Rdata_p to the RAM output; that output is shared by both ports and is qualified only by that port's o_Rvalid_p.

Reset
REQ-023 SHALL, while i_RESET_n is low, drive o_Gnt_p=0 and o_Rvalid_p=0, clear the burst counter, and set the round-robin pointer to "last = port 1".
REQ-024 SHALL discard a read accepted in the cycle reset asserts; no o_Rvalid_p pulse SHALL follow reset deassertion.
REQ-025 SHALL treat o_Rdata_p as undefined during reset and on the cycle after it.

Configuration
REQ-026 SHALL select arbitration with macro RAM_ARBITER_RR_EN:
- Defined: when both ports request outside a burst, the grant goes to the port not granted last.
- Defined: the pointer updates on every accepted transfer.
- Undefined: fixed priority per REQ-019, with no pointer register.
- Both modes: burst hold (REQ-020) behaves identically.

Structure
REQ-027 SHALL take the default DEPTH and WIDTH constants, the port-ID encoding (PORT0=0, PORT1=1) and the burst-counter width (4 bits) from shared package hack_mem_pkg.
REQ-028 SHALL instantiate the existing single-port RAM module as its only sub-module, with the same DEPTH and WIDTH.

Verification
REQ-029 SHALL pass the following directed scenarios:
- Single write then read: port 0 writes 0x1234 to address 5, then reads address 5 -> o_Rvalid_0 is high one cycle after the read grant with o_Rdata_0=0x1234; o_Rvalid_1 stays 0.
- Contention without RR: both ports read continuously for 3 cycles -> port 0 is granted all 3 cycles.
- Contention with RR: both ports read continuously -> grants alternate 0,1,0,1, starting with port 0 after reset.
- Burst cap: MAX_BURST=4, port 1 locked and requesting with port 0 requesting -> port 1 is granted 4 consecutive cycles, then port 0 is granted.
- Same-cycle contention: port 0 writes 0xBEEF to address 7 while port 1 reads address 7 (fixed priority) -> write is granted first; port 1's read, granted next, returns 0xBEEF.
- Reset mid-read: a read is accepted and i_RESET_n goes low that cycle -> no o_Rvalid pulse; both grants are 0 while reset is low.
